// File: rtl/kyber_pkg.sv
// Shared constants, mode encoding and constant-coefficient shift-add helpers for
// the Kyber Montgomery reduction pipeline.
package kyber_pkg;

    localparam int COEF_W = 16;
    localparam int DATA_W = 32;

    localparam logic [COEF_W-1:0] KYBER_Q    = 16'd3329;
    localparam logic [COEF_W-1:0] KYBER_QINV = 16'd62209;

    typedef enum logic {
        MODE_REDUCE = 1'b0,
        MODE_QINV   = 1'b1
    } mode_e;

    // Constant multiplies unrolled into shifted adds so no multiplier is inferred.
    function automatic logic [COEF_W-1:0] mul_qinv(input logic [COEF_W-1:0] x);
        logic [COEF_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < COEF_W; i++) begin
            if (KYBER_QINV[i]) acc = acc + (x << i);
        end
        return acc;
    endfunction

    function automatic logic signed [DATA_W-1:0] mul_q(input logic signed [COEF_W-1:0] t);
        logic signed [DATA_W-1:0] ext;
        logic signed [DATA_W-1:0] acc;
        ext = DATA_W'(t);
        acc = '0;
        for (int i = 0; i < COEF_W; i++) begin
            if (KYBER_Q[i]) acc = acc + (ext <<< i);
        end
        return acc;
    endfunction

    function automatic logic signed [COEF_W-1:0] canon_fix(input logic signed [COEF_W-1:0] r);
        return (r < 0) ? r + $signed(KYBER_Q) : r;
    endfunction

endpackage

// File: rtl/mont_reduce_lane.sv
// One lane of the S1-S3 Montgomery datapath; advances only when en_i is high.
// MONT_REDUCE_CANON_EN folds a negative mode-0 result into [0, Q-1] inside S3.
module mont_reduce_lane
    import kyber_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              mode_i,
    input  logic [DATA_W-1:0] a_i,
    output logic [COEF_W-1:0] res_o
);

    logic        [COEF_W-1:0] t_p1_d;
    logic        [COEF_W-1:0] t_p1_q;
    logic signed [COEF_W-1:0] a_hi_p1_q;
    mode_e                    mode_p1_q;

    logic signed [DATA_W-1:0] m_p2_d;
    logic signed [COEF_W-1:0] m_hi_p2_q;
    logic signed [COEF_W-1:0] a_hi_p2_q;
    logic        [COEF_W-1:0] t_p2_q;
    mode_e                    mode_p2_q;

    logic signed [COEF_W-1:0] diff_p3;
    logic        [COEF_W-1:0] res_p3_d;
    logic        [COEF_W-1:0] res_p3_q;

    // Low half of t*Q equals a[15:0] by construction, so only the high halves subtract.
    logic        [COEF_W-1:0] m_lo_unused;

    assign t_p1_d      = mul_qinv(a_i[COEF_W-1:0]);
    assign m_p2_d      = mul_q($signed(t_p1_q));
    assign m_lo_unused = m_p2_d[COEF_W-1:0];

    always_comb begin
        diff_p3 = a_hi_p2_q - m_hi_p2_q;
`ifdef MONT_REDUCE_CANON_EN
        diff_p3 = canon_fix(diff_p3);
`endif
        res_p3_d = (mode_p2_q == MODE_QINV) ? t_p2_q : diff_p3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_p1_q    <= '0;
            a_hi_p1_q <= '0;
            mode_p1_q <= MODE_REDUCE;
            m_hi_p2_q <= '0;
            a_hi_p2_q <= '0;
            t_p2_q    <= '0;
            mode_p2_q <= MODE_REDUCE;
            res_p3_q  <= '0;
        end else if (en_i) begin
            // S1: t, a_hi, mode
            t_p1_q    <= t_p1_d;
            a_hi_p1_q <= a_i[DATA_W-1:COEF_W];
            mode_p1_q <= mode_e'(mode_i);
            // S2: m = t*Q
            m_hi_p2_q <= m_p2_d[DATA_W-1:COEF_W];
            a_hi_p2_q <= a_hi_p1_q;
            t_p2_q    <= t_p1_q;
            mode_p2_q <= mode_p1_q;
            // S3: difference and mode mux
            res_p3_q  <= res_p3_d;
        end
    end

    assign res_o = res_p3_q;

endmodule

// File: rtl/mont_reduce_pipe.sv
// LANES-wide Montgomery reduction pipeline with valid/ready handshake and optional
// output register; MONT_REDUCE_CANON_EN selects canonical mode-0 results in the lanes.
module mont_reduce_pipe
    import kyber_pkg::*;
#(
    parameter int LANES   = 2,
    parameter int OUT_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_mode,
    input  logic [DATA_W*LANES-1:0]  in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [COEF_W*LANES-1:0]  out_data,
    output logic                     busy
);

    logic                    en;
    logic                    vld_p1_q;
    logic                    vld_p2_q;
    logic                    vld_p3_q;
    logic [COEF_W*LANES-1:0] res_p3;

    // A single global enable: the whole pipe freezes while the output is blocked.
    assign in_ready = !(out_valid && !out_ready);
    assign en       = in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
        end else if (en) begin
            vld_p1_q <= in_valid;
            vld_p2_q <= vld_p1_q;
            vld_p3_q <= vld_p2_q;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mont_reduce_lane u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_i   (en),
            .mode_i (in_mode),
            .a_i    (in_data[l*DATA_W +: DATA_W]),
            .res_o  (res_p3[l*COEF_W +: COEF_W])
        );
    end

    if (OUT_REG != 0) begin : g_oreg
        logic                    vld_p4_q;
        logic [COEF_W*LANES-1:0] data_p4_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p4_q  <= 1'b0;
                data_p4_q <= '0;
            end else if (en) begin
                // S4: output register
                vld_p4_q  <= vld_p3_q;
                data_p4_q <= res_p3;
            end
        end

        assign out_valid = vld_p4_q;
        assign out_data  = data_p4_q;
        assign busy      = vld_p1_q | vld_p2_q | vld_p3_q | vld_p4_q;
    end else begin : g_noreg
        assign out_valid = vld_p3_q;
        assign out_data  = res_p3;
        assign busy      = vld_p1_q | vld_p2_q | vld_p3_q;
    end

endmodule

// File: doc/mont_reduce_pipe.md
MONT_REDUCE_PIPE -- requirements
Module: mont_reduce_pipe

Interface
REQ-001 The block SHALL have parameter LANES, default 2, giving the number of parallel reduction lanes (legal 1..8).
REQ-002 The block SHALL have parameter OUT_REG, default 1, which adds an output register stage when 1 and omits it when 0.
REQ-003 Port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1 bit: the input beat is valid.
REQ-006 Port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-007 Port in_mode, input, 1 bit: 0 selects full Montgomery reduce; 1 selects the QINV-product-only mode.
REQ-008 Port in_data, input, 32*LANES bits: one signed 32-bit operand a per lane, with lane 0 in the LSBs.
REQ-009 Port out_valid, output, 1 bit: the output beat is valid.
REQ-010 Port out_ready, input, 1 bit: the downstream accepts the beat.
REQ-011 Port out_data, output, 16*LANES bits: one 16-bit result per lane.
REQ-012 Port busy, output, 1 bit: high when any pipeline stage holds a valid beat.

Function
REQ-013 The block SHALL compute per lane t = (a[15:0]*QINV) mod 2^16 using shift-add logic only, with no multiplier inference; QINV = 62209 (0xF301).
REQ-014 When mode=1, the lane result SHALL be t.
REQ-015 When mode=0, the lane result SHALL be r = (a - signed(t)*Q) >> 16 (arithmetic shift), with Q = 3329 and the result truncated to 16 bits.
REQ-016 The valid operand range SHALL be |a| < Q*2^15; results for operands outside this range are unspecified but SHALL NOT corrupt other lanes or other beats.
REQ-017 Pipeline stages: S1 registers t, a_hi and mode; S2 registers m = signed(t)*Q as a 32-bit shift-add product; S3 registers the difference, shift and mode mux; an optional S4 is present when OUT_REG=1.
REQ-018 Latency SHALL be 3 cycles from an accepted beat to out_valid with OUT_REG=0, and 4 cycles with OUT_REG=1.
REQ-019 Each stage SHALL carry its own valid bit, and mode SHALL travel with its beat.
REQ-020 Stall rule: in_ready = !(out_valid && !out_ready); when stalled, all stage registers SHALL hold their contents.
REQ-021 A beat SHALL be accepted only when in_valid && in_ready.
REQ-022 The pipeline SHALL sustain one beat per cycle with no bubbles while out_ready=1.
REQ-023 out_data and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 If in_valid and an output handshake occur in the same cycle, both SHALL take effect; no beat is lost or duplicated.
REQ-025 Beats SHALL leave in acceptance order, and lanes SHALL be fully independent.

Reset
REQ-026 On rst_n low, all stage valid bits SHALL clear immediately, so out_valid=0 and busy=0.
REQ-027 While rst_n is low, out_data SHALL read 0 and in_ready SHALL be 1.
REQ-028 Data registers SHALL also be reset to 0, so no X values appear on out_data.
REQ-029 A reset asserted mid-operation SHALL discard all in-flight beats.
REQ-030 The first beat SHALL be accepted on the first rising edge after rst_n is released.

Configuration
REQ-031 Macro MONT_REDUCE_CANON_EN SHALL control final correction in mode 0.
REQ-032 With MONT_REDUCE_CANON_EN defined, the mode-0 result SHALL be corrected into the canonical range [0, Q-1] by adding Q when r < 0, inside S3 with no added latency.
REQ-033 Without MONT_REDUCE_CANON_EN, the mode-0 result SHALL be signed in (-Q, Q).
REQ-034 Mode 1 SHALL be unaffected by MONT_REDUCE_CANON_EN.

Structure
REQ-035 Package kyber_pkg SHALL hold KYBER_Q=3329, KYBER_QINV=62209, the 16- and 32-bit coefficient width constants, and the mode encoding.
REQ-036 The block SHALL contain one sub-module, mont_reduce_lane (the S1-S3 datapath for one lane), instantiated LANES times; handshake and valid control SHALL live only in the top module.

Verification
REQ-037 Reset and mode 0: reset, then apply LANES=2, a={0, 1} in mode 0 -> 3 cycles later (OUT_REG=0) out_data lanes = {0, 169}.
REQ-038 Mode 0, exact multiple: a=3329 -> result 0; a=-1 -> result -169 (0xFF57), or 3160 with MONT_REDUCE_CANON_EN.
REQ-039 Mode 1: a=1 -> result 0xF301; a=0x0001_0002 -> result 0xE602.
REQ-040 Backpressure: drive 8 back-to-back beats, hold out_ready=0 for 5 cycles mid-stream -> all 8 results arrive in order, with no duplicates and out_data stable while stalled.
REQ-041 Reset mid-operation: assert rst_n low with 3 beats in flight -> out_valid=0 at once, and none of the 3 beats ever emerges after release.
REQ-042 Random regression: 10^5 random a with |a| < Q*2^15 and mixed modes, with both OUT_REG values and both macro settings -> all results match the reference model.
